// File: rtl/video_timing_gen.sv
// Raster timing generator: walks h/v counters over a full frame, issues frame-buffer
// reads for active pixels and emits encoder controls delayed to match RAM latency.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned HS_POL    = 1,
  parameter int unsigned VS_POL    = 1,
  parameter int unsigned ADDR_W    = 26,
  parameter int unsigned ADDR_BASE = 0,
  parameter int unsigned LAT       = 2
) (
  input  logic              clk_low,
  input  logic              reset,
  input  logic              enable,
  output logic              rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [11:0]       pix_x,
  output logic [11:0]       pix_y,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start,
  output logic              busy
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int unsigned HS_LO   = H_ACTIVE + H_FP;
  localparam int unsigned HS_HI   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_LO   = V_ACTIVE + V_FP;
  localparam int unsigned VS_HI   = V_ACTIVE + V_FP + V_SYNC;

  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_e;

  state_e            state_q, state_d;
  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic              h_last, v_last;

  logic              run_d, act_d, fs_d, hs_d, vs_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0]       px_d, py_d;

  logic              rd_en_q, fs_q, busy_q, hs_q, vs_q;
  logic [11:0]       px_q, py_q;
  logic              de_raw, hs_raw, vs_raw;

  // Next-state and next-position logic; (h,v) always names the pixel on the outputs.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    h_last  = (32'(h_q) == H_TOTAL - 1);
    v_last  = (32'(v_q) == V_TOTAL - 1);
    case (state_q)
      IDLE: begin
        h_d = '0;
        v_d = '0;
        if (enable) state_d = RUN;
      end
      RUN, STOP_PEND: begin
        if (h_last) begin
          h_d = '0;
          v_d = v_last ? '0 : v_q + VW'(1);
        end else begin
          h_d = h_q + HW'(1);
        end
        if (state_q == STOP_PEND && h_last && v_last) begin
          state_d = IDLE;
          h_d     = '0;
          v_d     = '0;
        end else begin
          state_d = enable ? RUN : STOP_PEND;
        end
      end
      default: begin
        state_d = IDLE;
        h_d     = '0;
        v_d     = '0;
      end
    endcase
  end

  // Output values for the pixel that becomes current at the next edge.
  always_comb begin
    run_d  = (state_d != IDLE);
    act_d  = run_d && (32'(h_d) < H_ACTIVE) && (32'(v_d) < V_ACTIVE);
    fs_d   = run_d && (h_d == '0) && (v_d == '0);
    hs_d   = run_d && (32'(h_d) >= HS_LO) && (32'(h_d) < HS_HI);
    vs_d   = run_d && (32'(v_d) >= VS_LO) && (32'(v_d) < VS_HI);
    px_d   = act_d ? 12'(h_d) : 12'(0);
    py_d   = act_d ? 12'(v_d) : 12'(0);
    addr_d = addr_q;
    if (fs_d) begin
      addr_d = ADDR_W'(ADDR_BASE);
    end else if (rd_en_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_low or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      addr_q  <= ADDR_W'(ADDR_BASE);
      rd_en_q <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      addr_q  <= addr_d;
      rd_en_q <= act_d;
      fs_q    <= fs_d;
      busy_q  <= run_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end

  // Encoder controls trail the read strobe by the RAM latency; idle shifts in zeros.
  generate
    if (LAT == 0) begin : g_nodly
      assign de_raw = rd_en_q;
      assign hs_raw = hs_q;
      assign vs_raw = vs_q;
    end else begin : g_dly
      logic [LAT-1:0] de_dly_q, hs_dly_q, vs_dly_q;
      always_ff @(posedge clk_low or posedge reset) begin
        if (reset) begin
          de_dly_q <= '0;
          hs_dly_q <= '0;
          vs_dly_q <= '0;
        end else begin
          de_dly_q <= (de_dly_q << 1) | LAT'(rd_en_q);
          hs_dly_q <= (hs_dly_q << 1) | LAT'(hs_q);
          vs_dly_q <= (vs_dly_q << 1) | LAT'(vs_q);
        end
      end
      assign de_raw = de_dly_q[LAT-1];
      assign hs_raw = hs_dly_q[LAT-1];
      assign vs_raw = vs_dly_q[LAT-1];
    end
  endgenerate

  assign rd_en       = rd_en_q;
  assign ram_addr    = addr_q;
  assign pix_x       = px_q;
  assign pix_y       = py_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign de          = de_raw;
  assign hsync       = (HS_POL != 0) ? hs_raw : ~hs_raw;
  assign vsync       = (VS_POL != 0) ? vs_raw : ~vs_raw;

endmodule
